tinyml_display_stream_router: RTL and testbench

- Packet-driven front end of the display annotation path, next generation of the fixed-format annotator.
- Parses a 64-bit DMA word stream into typed packets: image pixels, bounding-box records, logo/overlay pixels.
- Forwards image and bbox payloads to the external bbox-drawing block and merges drawn pixels and logo words into an internal FWFT output FIFO.
- Adds header-specified lengths, generalised DMA alignment padding, in_last resynchronisation and error reporting.

---
 rtl/tinyml_display_stream_router.sv | 191 +++++++++++++++++++
 tb/tb_tinyml_display_stream_router.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/tinyml_display_stream_router.sv
// Packet router for the display annotation path: parses header/payload/pad words, feeds the bbox drawer,
// and merges drawn pixels with logo words into a FWFT output FIFO. Optional stats: TINYML_ROUTER_STATS_EN.
module tinyml_display_stream_router #(
  parameter int DATA_WIDTH   = 64,
  parameter int FRAME_WIDTH  = 540,
  parameter int FRAME_HEIGHT = 540,
  parameter int PPC          = 2,
  parameter int MAX_BBOX     = 16,
  parameter int LOGO_WIDTH   = 540,
  parameter int LOGO_HEIGHT  = 100,
  parameter int FIFO_DEPTH   = 16,
  parameter int FIFO_AFULL   = 10,
  parameter int ALIGN_WORDS  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  img_valid,
  output logic                  bbox_valid,
  output logic [DATA_WIDTH-1:0] pay_data,
  input  logic                  draw_valid,
  input  logic [DATA_WIDTH-1:0] draw_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  err_pulse,
  output logic [1:0]            err_code
`ifdef TINYML_ROUTER_STATS_EN
  ,
  output logic [15:0]           pkt_count,
  output logic [7:0]            err_count
`endif
);

  localparam int CW = 20;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] IMG_LEN    = CW'(FRAME_WIDTH * FRAME_HEIGHT / PPC);
  localparam logic [CW-1:0] BBOX_LEN   = CW'(MAX_BBOX);
  localparam logic [CW-1:0] LOGO_LEN   = CW'(LOGO_WIDTH * LOGO_HEIGHT / PPC);
  localparam logic [CW-1:0] ALIGN_MASK = CW'(ALIGN_WORDS - 1);

  // Payload state encodings equal the header type codes, so a known type maps straight to its state.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_IMAGE = 3'd1;
  localparam logic [2:0] S_BBOX  = 3'd2;
  localparam logic [2:0] S_LOGO  = 3'd3;
  localparam logic [2:0] S_PAD   = 3'd4;
  localparam logic [2:0] S_DROP  = 3'd5;

  logic [2:0]      state;
  logic [CW-1:0]   cnt, len_r, pad_r;
  logic [2:0]      hdr_type;
  logic [CW-1:0]   hdr_len, eff_len, hdr_pad;
  logic            hdr_known, acc, in_payload, last_word;
  logic            unknown_err, early_err, ovf_err, pkt_done;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            full, pop, wr_req, wr_en;
  logic [DATA_WIDTH-1:0] wr_data;

  assign hdr_type = in_data[2:0];
  assign hdr_len  = in_data[27:8];

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    eff_len   = hdr_len;
    hdr_known = 1'b1;
    case (hdr_type)
      3'd1:    if (hdr_len == '0) eff_len = IMG_LEN;
      3'd2:    if (hdr_len == '0) eff_len = BBOX_LEN;
      3'd3:    if (hdr_len == '0) eff_len = LOGO_LEN;
      default: hdr_known = 1'b0;
    endcase
  end

  assign hdr_pad = (CW'(ALIGN_WORDS) - ((eff_len + CW'(1)) & ALIGN_MASK)) & ALIGN_MASK;

  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign in_ready = (count < (AW+1)'(FIFO_AFULL)) & ~((state == S_LOGO) & draw_valid);
  assign acc      = in_valid & in_ready;

  assign in_payload  = (state == S_IMAGE) | (state == S_BBOX) | (state == S_LOGO);
  assign last_word   = (cnt == len_r - CW'(1));
  assign pkt_done    = acc & in_payload & last_word;
  assign early_err   = acc & in_payload & in_last & ~last_word;
  assign unknown_err = acc & (state == S_IDLE) & ~hdr_known;

  assign img_valid  = acc & (state == S_IMAGE);
  assign bbox_valid = acc & (state == S_BBOX);
  assign pay_data   = in_data;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      len_r <= '0;
      pad_r <= '0;
    end else if (acc) begin
      case (state)
        S_IDLE: begin
          cnt   <= '0;
          len_r <= eff_len;
          pad_r <= hdr_pad;
          if (!in_last) state <= hdr_known ? hdr_type : S_DROP;
        end
        S_IMAGE, S_BBOX, S_LOGO: begin
          // in_last always resynchronises to a header, whether early or on the final word.
          if (in_last) begin
            state <= S_IDLE;
          end else if (last_word) begin
            cnt   <= '0;
            state <= (pad_r != '0) ? S_PAD : S_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_PAD: begin
          if (in_last || cnt == pad_r - CW'(1)) state <= S_IDLE;
          else                                  cnt   <= cnt + CW'(1);
        end
        S_DROP:  if (in_last) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Drawer has no backpressure, so it wins; in_ready already blocks logo words while it is active.
  assign wr_req  = draw_valid | (acc & (state == S_LOGO));
  assign wr_data = draw_valid ? draw_data : in_data;
  assign pop     = out_ready & out_valid;
  assign wr_en   = wr_req & (~full | pop);
  assign ovf_err = wr_req & full & ~pop;

  // NOTE: storage is not reset; validity is tracked only by the pointers and count.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_pulse <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      err_pulse <= unknown_err | early_err | ovf_err;
      if      (unknown_err) err_code <= 2'd1;
      else if (early_err)   err_code <= 2'd2;
      else if (ovf_err)     err_code <= 2'd3;
    end
  end

`ifdef TINYML_ROUTER_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_count <= '0;
      err_count <= '0;
    end else begin
      if (pkt_done)                    pkt_count <= pkt_count + 16'd1;
      if (err_pulse && err_count != '1) err_count <= err_count + 8'd1;
    end
  end
`else
  logic unused_pkt_done;
  assign unused_pkt_done = pkt_done;
`endif

endmodule

// File: tb/tb_tinyml_display_stream_router.sv
// Directed self-checking bench for tinyml_display_stream_router with default parameters.
module tb_tinyml_display_stream_router;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          img_valid, bbox_valid;
  logic [DW-1:0] pay_data;
  logic          draw_valid = 1'b0;
  logic [DW-1:0] draw_data = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic          err_pulse;
  logic [1:0]    err_code;

  int n_assert = 0;
  int n_fail   = 0;
  int img_seen = 0;
  int bbox_seen = 0;
  logic [DW-1:0] last_pay = '0;

  always #5 clk = ~clk;

  tinyml_display_stream_router dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_last(in_last), .in_data(in_data), .in_ready(in_ready),
    .img_valid(img_valid), .bbox_valid(bbox_valid), .pay_data(pay_data),
    .draw_valid(draw_valid), .draw_data(draw_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .err_pulse(err_pulse), .err_code(err_code)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one word from a negedge and hold it until accepted, with a bounded wait.
  task automatic send(input logic [63:0] d, input logic last);
    int waits = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    #1;
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (!in_ready) begin
      n_assert++;
      n_fail++;
      $error("FAIL send_timeout: observed in_ready=0 expected 1 for word 0x%0h", d);
    end
    if (img_valid)  img_seen++;
    if (bbox_valid) bbox_seen++;
    if (img_valid || bbox_valid) last_pay = pay_data;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [63:0] exp);
    @(negedge clk);
    #1;
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    check(tag, out_data, exp);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int b0, i0, errs;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_img_valid", {63'd0, img_valid}, 64'd0);
    check("rst_bbox_valid", {63'd0, bbox_valid}, 64'd0);
    check("rst_err_pulse", {63'd0, err_pulse}, 64'd0);
    check("rst_err_code", {62'd0, err_code}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // BBOX default length 16, one pad word
    send(64'h2, 1'b0);
    for (int i = 0; i < 16; i++) send(64'h1000 + 64'(i), 1'b0);
    check("bbox_pulses", 64'(bbox_seen), 64'd16);
    check("bbox_last_pay", last_pay, 64'h100F);
    check("bbox_no_img", 64'(img_seen), 64'd0);
    send(64'hDEAD, 1'b0);
    check("pad_no_bbox", 64'(bbox_seen), 64'd16);
    check("pad_no_fifo", {63'd0, out_valid}, 64'd0);

    // LOGO explicit length 5, no pad
    send(64'h503, 1'b0);
    send(64'hA0, 1'b0);
    check("logo_first_valid", {63'd0, out_valid}, 64'd1);
    check("logo_first_data", out_data, 64'hA0);
    for (int i = 1; i < 5; i++) send(64'hA0 + 64'(i), 1'b0);
    send(64'h101, 1'b0);
    send(64'hB0, 1'b0);
    check("after_logo_img", 64'(img_seen), 64'd1);
    check("after_logo_pay", last_pay, 64'hB0);
    for (int i = 0; i < 5; i++) pop_check("logo_order", 64'hA0 + 64'(i));
    check("logo_drained", {63'd0, out_valid}, 64'd0);

    // Drawer merge during LOGO
    send(64'h303, 1'b0);
    @(negedge clk);
    draw_valid = 1'b1;
    draw_data  = 64'hE0;
    in_valid   = 1'b1;
    in_data    = 64'hC0;
    #1;
    check("merge_block0", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    draw_data = 64'hE1;
    #1;
    check("merge_block1", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    draw_valid = 1'b0;
    in_valid   = 1'b0;
    for (int i = 0; i < 3; i++) send(64'hC0 + 64'(i), 1'b0);
    pop_check("merge_e0", 64'hE0);
    pop_check("merge_e1", 64'hE1);
    for (int i = 0; i < 3; i++) pop_check("merge_logo", 64'hC0 + 64'(i));
    check("merge_drained", {63'd0, out_valid}, 64'd0);

    // Backpressure and overflow
    send(64'hF03, 1'b0);
    for (int i = 0; i < 10; i++) send(64'h5000 + 64'(i), 1'b0);
    check("afull_in_ready", {63'd0, in_ready}, 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      draw_valid = 1'b1;
      draw_data  = 64'h6000 + 64'(i);
      @(posedge clk);
      #1;
      check("fill_no_err", {63'd0, err_pulse}, 64'd0);
    end
    errs = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      draw_data = 64'h6006 + 64'(i);
      @(posedge clk);
      #1;
      if (err_pulse) errs++;
      check("ovf_code", {62'd0, err_code}, 64'd3);
    end
    check("ovf_pulses", 64'(errs), 64'd7);
    @(negedge clk);
    draw_valid = 1'b0;
    @(posedge clk);
    #1;
    check("ovf_pulse_end", {63'd0, err_pulse}, 64'd0);
    check("ovf_code_held", {62'd0, err_code}, 64'd3);
    for (int i = 0; i < 16; i++)
      pop_check("drain", (i < 10) ? 64'h5000 + 64'(i) : 64'h6000 + 64'(i - 10));
    check("drain_empty", {63'd0, out_valid}, 64'd0);
    for (int i = 10; i < 15; i++) send(64'h5000 + 64'(i), 1'b0);
    for (int i = 10; i < 15; i++) pop_check("logo_tail", 64'h5000 + 64'(i));

    // Unknown type dropped until in_last
    b0 = bbox_seen;
    i0 = img_seen;
    send(64'h5, 1'b0);
    check("unk_pulse", {63'd0, err_pulse}, 64'd1);
    check("unk_code", {62'd0, err_code}, 64'd1);
    send(64'h77, 1'b0);
    check("unk_pulse_once", {63'd0, err_pulse}, 64'd0);
    send(64'h78, 1'b0);
    send(64'h79, 1'b1);
    check("drop_no_fifo", {63'd0, out_valid}, 64'd0);
    check("drop_no_pay", 64'(img_seen + bbox_seen - i0 - b0), 64'd0);

    // Early in_last inside IMAGE len 8
    i0 = img_seen;
    send(64'h801, 1'b0);
    for (int i = 1; i < 4; i++) send(64'h7000 + 64'(i), 1'b0);
    send(64'h7004, 1'b1);
    check("early_pulse", {63'd0, err_pulse}, 64'd1);
    check("early_code", {62'd0, err_code}, 64'd2);
    check("early_img_cnt", 64'(img_seen - i0), 64'd4);
    b0 = bbox_seen;
    send(64'h102, 1'b0);
    check("early_resync_pulse", {63'd0, err_pulse}, 64'd0);
    send(64'hBB, 1'b0);
    check("early_resync_bbox", 64'(bbox_seen - b0), 64'd1);
    check("early_resync_pay", last_pay, 64'hBB);

    // Reset in the middle of a default IMAGE packet with a non-empty FIFO
    send(64'h1, 1'b0);
    for (int i = 0; i < 100; i++) send(64'h8000 + 64'(i), 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      draw_valid = 1'b1;
      draw_data  = 64'h9000 + 64'(i);
    end
    @(negedge clk);
    draw_valid = 1'b0;
    #1;
    check("pre_rst_fifo", {63'd0, out_valid}, 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_err_code", {62'd0, err_code}, 64'd0);
    check("mid_rst_err_pulse", {63'd0, err_pulse}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    b0 = bbox_seen;
    i0 = img_seen;
    send(64'h2, 1'b0);
    send(64'hCC, 1'b0);
    check("post_rst_bbox", 64'(bbox_seen - b0), 64'd1);
    check("post_rst_no_img", 64'(img_seen - i0), 64'd0);
    check("post_rst_fifo", {63'd0, out_valid}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
